vdp99_cpu_port: RTL
===================

VDP99_CPU_PORT -- requirements
Module: vdp99_cpu_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the VRAM address width in bits.
REQ-002 SHALL have port pxclk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_tick  in  1  one-cycle CPU write strobe.
REQ-005 SHALL have port rd_tick  in  1  one-cycle CPU read strobe.
REQ-006 SHALL have port mode  in  1  port select: 0 = data port, 1 = control/status port; valid in the tick cycle.
REQ-007 SHALL have port din  in  8  CPU write data; valid in the wr_tick cycle.
REQ-008 SHALL have port dout  out  8  CPU read data.
REQ-009 SHALL have port vram_req  out  1  VRAM access request.
REQ-010 SHALL have port vram_we  out  1  request is a write (1) or a read (0).
REQ-011 SHALL have port vram_addr  out  ADDR_W  VRAM address.
REQ-012 SHALL have port vram_wdata  out  8  VRAM write data.
REQ-013 SHALL have port vram_ack  in  1  one-cycle grant from the display arbiter; the access completes in that cycle.
REQ-014 SHALL have port vram_rdata  in  8  VRAM read data; valid in the vram_ack cycle.
REQ-015 SHALL have port reg_wr  out  1  one-cycle register-write strobe.
REQ-016 SHALL have port reg_num  out  3  register number for the write.
REQ-017 SHALL have port reg_data  out  8  register value for the write.
REQ-018 SHALL have port status_in  in  8  current VDP status byte.
REQ-019 SHALL have port status_rd  out  1  one-cycle pulse that clears the status flags.
REQ-020 SHALL have port overrun  out  1  sticky flag: a CPU access was dropped.

Function
REQ-021 SHALL hold internal state: addr (ADDR_W bits), read-ahead buffer rbuf (8), control temp byte ctmp (8), first-byte flag cflag, and state machine IDLE/BUSY.
REQ-022 SHALL give wr_tick priority when wr_tick and rd_tick arrive in the same cycle; the rd_tick is ignored and overrun is not set.
REQ-023 SHALL drive dout combinationally: status_in when mode=1, rbuf when mode=0, so dout is valid in the rd_tick cycle itself.
REQ-024 SHALL, on a control write with cflag=0, load ctmp<=din and set cflag=1.
REQ-025 SHALL, on a control write with cflag=1 and din[7]=1, pulse reg_wr the next cycle with reg_num=din[2:0] and reg_data=ctmp, then clear cflag; this is accepted in any state.
REQ-026 SHALL, on a control write with cflag=1 and din[7]=0, set addr<={din[5:0],ctmp} (bits above ADDR_W truncated) and clear cflag.
REQ-027 SHALL, when din[6]=0 in that second byte (read setup), additionally start a VRAM read prefetch.
REQ-028 SHALL, on a status read (mode=1), pulse status_rd the next cycle and clear cflag; this is accepted in any state.
REQ-029 SHALL, on a data write, set rbuf<=din and start a VRAM write of din at addr.
REQ-030 SHALL, on a data read, start a VRAM read prefetch; dout has already presented the old rbuf.
REQ-031 SHALL clear cflag on every data-port access.
REQ-032 SHALL, on starting a VRAM access, move IDLE->BUSY and assert vram_req, vram_we, vram_addr and vram_wdata from the next cycle, holding them stable until vram_ack.
REQ-033 SHALL, in the vram_ack cycle, load rbuf<=vram_rdata for reads, increment addr modulo 2^ADDR_W (3FFF->0000), drop vram_req on the next cycle and return to IDLE.
REQ-034 SHALL ignore vram_ack while IDLE.
REQ-035 SHALL, while BUSY, drop data-port accesses and second control bytes with din[7]=0 (addr, rbuf and cflag unchanged) and set overrun.
REQ-036 SHALL clear overrun only on reset.

Reset
REQ-037 SHALL, while reset is high, force: state IDLE, vram_req=0, vram_we=0, reg_wr=0, status_rd=0, overrun=0, cflag=0, addr=0, rbuf=0, ctmp=0, reg_num=0, reg_data=0, vram_wdata=0.
REQ-038 SHALL abandon any in-flight request when reset is asserted mid-access; vram_req=0 on the cycle after reset is sampled.

Verification
REQ-039 SHALL cover: control writes 0x34 then 0x47, then data write 0xA5, ack after 3 cycles -> vram_req=1 with vram_we=1, vram_addr=0x0734 and vram_wdata=0xA5 until ack; afterwards addr=0x0735.
REQ-040 SHALL cover: control writes 0x00 then 0x10, ack with vram_rdata=0x5A, then data read -> dout=0x5A in the rd_tick cycle, next prefetch at 0x1001.
REQ-041 SHALL cover: control writes 0xF0 then 0x87 -> one reg_wr pulse with reg_num=7 and reg_data=0xF0; no vram_req.
REQ-042 SHALL cover: control write 0x12, then status read with status_in=0x80, then control write 0x34 -> dout=0x80, one status_rd pulse, cflag restarted so ctmp=0x34 and no reg_wr.
REQ-043 SHALL cover: write setup to 0x3FFF, two data writes each acked -> addresses 0x3FFF then 0x0000.
REQ-044 SHALL cover: data write issued while BUSY -> dropped, overrun=1, addr unchanged; reset asserted while BUSY -> vram_req=0 and overrun=0 the next cycle.

Source files
------------

// File: rtl/vdp99_cpu_port.sv
// vdp99_cpu_port: CPU-side data/control port of a TMS9918-style VDP.
// Sequences the two-byte control writes, the VRAM address auto-increment,
// the read-ahead buffer and single outstanding VRAM accesses to the arbiter.
module vdp99_cpu_port #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic              rd_tick,
  input  logic              mode,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              reg_wr,
  output logic [2:0]        reg_num,
  output logic [7:0]        reg_data,
  input  logic [7:0]        status_in,
  output logic              status_rd,
  output logic              overrun
);

  localparam int unsigned SETUP_W = 14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_rbuf;
  logic [7:0]          r_ctmp;
  logic                r_cflag;
  logic                r_vram_req;
  logic                r_vram_we;
  logic [ADDR_W-1:0]   r_vram_addr;
  logic [7:0]          r_vram_wdata;
  logic                r_reg_wr;
  logic [2:0]          r_reg_num;
  logic [7:0]          r_reg_data;
  logic                r_status_rd;
  logic                r_overrun;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [7:0]          w_rbuf_nxt;
  logic [7:0]          w_ctmp_nxt;
  logic                w_cflag_nxt;
  logic                w_vram_req_nxt;
  logic                w_vram_we_nxt;
  logic [ADDR_W-1:0]   w_vram_addr_nxt;
  logic [7:0]          w_vram_wdata_nxt;
  logic                w_reg_wr_nxt;
  logic [2:0]          w_reg_num_nxt;
  logic [7:0]          w_reg_data_nxt;
  logic                w_status_rd_nxt;
  logic                w_overrun_nxt;

  logic                w_busy;
  logic                w_start;
  logic                w_start_we;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [7:0]          w_start_wdata;
  logic [SETUP_W-1:0]  w_setup;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_setup = {din[5:0], r_ctmp};

  // Read data is combinational so the CPU sees it in its own read cycle
  assign dout = mode ? status_in : r_rbuf;

  assign vram_req   = r_vram_req;
  assign vram_we    = r_vram_we;
  assign vram_addr  = r_vram_addr;
  assign vram_wdata = r_vram_wdata;
  assign reg_wr     = r_reg_wr;
  assign reg_num    = r_reg_num;
  assign reg_data   = r_reg_data;
  assign status_rd  = r_status_rd;
  assign overrun    = r_overrun;

  // Next-state: CPU tick decode, VRAM completion and access launch
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_rbuf_nxt       = r_rbuf;
    w_ctmp_nxt       = r_ctmp;
    w_cflag_nxt      = r_cflag;
    w_vram_req_nxt   = r_vram_req;
    w_vram_we_nxt    = r_vram_we;
    w_vram_addr_nxt  = r_vram_addr;
    w_vram_wdata_nxt = r_vram_wdata;
    w_reg_wr_nxt     = 1'b0;
    w_reg_num_nxt    = r_reg_num;
    w_reg_data_nxt   = r_reg_data;
    w_status_rd_nxt  = 1'b0;
    w_overrun_nxt    = r_overrun;
    w_start          = 1'b0;
    w_start_we       = 1'b0;
    w_start_addr     = r_addr;
    w_start_wdata    = r_vram_wdata;

    // Completion; ticks that could touch addr/rbuf are dropped while busy
    if (w_busy && vram_ack) begin
      w_state_nxt    = ST_IDLE;
      w_vram_req_nxt = 1'b0;
      if (!r_vram_we) begin
        w_rbuf_nxt = vram_rdata;
      end
      w_addr_nxt = r_addr + ADDR_W'(1);
    end

    if (wr_tick) begin
      if (mode) begin
        if (!r_cflag) begin
          w_ctmp_nxt  = din;
          w_cflag_nxt = 1'b1;
        end else if (din[7]) begin
          w_reg_wr_nxt   = 1'b1;
          w_reg_num_nxt  = din[2:0];
          w_reg_data_nxt = r_ctmp;
          w_cflag_nxt    = 1'b0;
        end else if (w_busy) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_addr_nxt   = ADDR_W'(w_setup);
          w_cflag_nxt  = 1'b0;
          w_start      = !din[6];
          w_start_we   = 1'b0;
          w_start_addr = ADDR_W'(w_setup);
        end
      end else if (w_busy) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_rbuf_nxt    = din;
        w_cflag_nxt   = 1'b0;
        w_start       = 1'b1;
        w_start_we    = 1'b1;
        w_start_wdata = din;
      end
    end else if (rd_tick) begin
      if (mode) begin
        w_status_rd_nxt = 1'b1;
        w_cflag_nxt     = 1'b0;
      end else if (w_busy) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_cflag_nxt = 1'b0;
        w_start     = 1'b1;
        w_start_we  = 1'b0;
      end
    end

    if (w_start) begin
      w_state_nxt      = ST_BUSY;
      w_vram_req_nxt   = 1'b1;
      w_vram_we_nxt    = w_start_we;
      w_vram_addr_nxt  = w_start_addr;
      w_vram_wdata_nxt = w_start_wdata;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pxclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_rbuf       <= '0;
      r_ctmp       <= '0;
      r_cflag      <= 1'b0;
      r_vram_req   <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_reg_wr     <= 1'b0;
      r_reg_num    <= '0;
      r_reg_data   <= '0;
      r_status_rd  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_rbuf       <= w_rbuf_nxt;
      r_ctmp       <= w_ctmp_nxt;
      r_cflag      <= w_cflag_nxt;
      r_vram_req   <= w_vram_req_nxt;
      r_vram_we    <= w_vram_we_nxt;
      r_vram_addr  <= w_vram_addr_nxt;
      r_vram_wdata <= w_vram_wdata_nxt;
      r_reg_wr     <= w_reg_wr_nxt;
      r_reg_num    <= w_reg_num_nxt;
      r_reg_data   <= w_reg_data_nxt;
      r_status_rd  <= w_status_rd_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

endmodule
